// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: FSM state encoding,
// decoded key codes, ALU operation codes and small key-classification helpers.
package calc_pkg;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        WAIT,
        SHOW,
        ERR
    } state_t;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_NOP = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

    function automatic logic is_oper(input logic [3:0] k);
        return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        logic [1:0] op;
        case (k)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// BCD operand entry register: a W-bit shift register of BCD digits plus a
// saturating digit counter.
//   i_clear      : zero value and count (applied before a same-cycle shift)
//   i_shift      : shift i_digit in at the LSB nibble unless already full
//   i_load       : load i_load_value and mark the operand full (wins over all)
//   o_value      : registered operand
//   o_value_next : value the register takes at the next clock edge
//   o_count      : number of digits held
module bcd_entry_reg
    import calc_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int W      = 4 * DIGITS,
    localparam int CW     = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_shift,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [3:0]    i_digit,
    input  logic [W-1:0]  i_load_value,
    output logic [W-1:0]  o_value,
    output logic [W-1:0]  o_value_next,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_value;
    logic [CW-1:0] r_count;
    logic [W-1:0]  w_base_v;
    logic [CW-1:0] w_base_c;
    logic [W-1:0]  w_next_v;
    logic [CW-1:0] w_next_c;

    // Clear is folded in before the shift so "clear then take this digit"
    // works in a single cycle.
    always_comb begin
        w_base_v = i_clear ? '0 : r_value;
        w_base_c = i_clear ? '0 : r_count;
        w_next_v = w_base_v;
        w_next_c = w_base_c;
        if (i_load) begin
            w_next_v = i_load_value;
            w_next_c = CW'(DIGITS);
        end else if (i_shift && (w_base_c < CW'(DIGITS))) begin
            w_next_v = {w_base_v[W-5:0], i_digit};
            w_next_c = w_base_c + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_value <= '0;
            r_count <= '0;
        end else begin
            r_value <= w_next_v;
            r_count <= w_next_c;
        end
    end

    assign o_value      = r_value;
    assign o_value_next = w_next_v;
    assign o_count      = r_count;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: collects operand A, operator and operand B from
// decoded key strobes, issues one ALU start, waits (with timeout) for the
// ALU's done and holds the result for the display.
//   clk, reset (async, active low), enable (freezes keys and timeout)
//   key_valid/key_code : decoded key strobe (0-9, A+, B-, C*, D nop, E=, F clr)
//   alu_a/alu_b/alu_op/alu_start : ALU request, owned solely here
//   alu_done/alu_ovf/alu_result  : ALU response, sampled on alu_done
//   display_value : BCD value to show; busy in EXEC/WAIT; error in ERR
// Optional: define CALC_SEQ_CHAIN_EN to let an operator in SHOW chain the
// result into operand A.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter  int DIGITS  = 4,
    parameter  int TIMEOUT = 255,
    localparam int W       = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    output logic         alu_start,
    input  logic         alu_done,
    input  logic         alu_ovf,
    input  logic [W-1:0] alu_result,
    output logic [W-1:0] display_value,
    output logic         busy,
    output logic         error
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(DIGITS + 1);

    state_t        r_state, w_state_n;
    logic [1:0]    r_op, w_op_n;
    logic [W-1:0]  r_result, w_result_n;
    logic [TW-1:0] r_tmo, w_tmo_n;
    logic [W-1:0]  r_display, w_display_n;
    logic          r_start, r_busy, r_error;

    logic          w_a_shift, w_a_clear, w_a_load;
    logic          w_b_shift, w_b_clear;
    logic [W-1:0]  w_a_next, w_b_next;
    logic [CW-1:0] w_a_count, w_b_count;

    logic w_key, w_clr, w_dig, w_opk, w_eq;

    assign w_key = key_valid && enable && (key_code != KEY_NOP);
    assign w_clr = w_key && (key_code == KEY_CLR);
    assign w_dig = w_key && is_digit(key_code);
    assign w_opk = w_key && is_oper(key_code);
    assign w_eq  = w_key && (key_code == KEY_EQ);

    bcd_entry_reg #(.DIGITS(DIGITS)) u_opa (
        .clk          (clk),
        .reset        (reset),
        .i_shift      (w_a_shift),
        .i_clear      (w_a_clear),
        .i_load       (w_a_load),
        .i_digit      (key_code),
        .i_load_value (r_result),
        .o_value      (alu_a),
        .o_value_next (w_a_next),
        .o_count      (w_a_count)
    );

    bcd_entry_reg #(.DIGITS(DIGITS)) u_opb (
        .clk          (clk),
        .reset        (reset),
        .i_shift      (w_b_shift),
        .i_clear      (w_b_clear),
        .i_load       (1'b0),
        .i_digit      (key_code),
        .i_load_value ('0),
        .o_value      (alu_b),
        .o_value_next (w_b_next),
        .o_count      (w_b_count)
    );

    always_comb begin
        assert (w_a_count <= CW'(DIGITS));
        assert (w_b_count <= CW'(DIGITS));
    end

    always_comb begin
        w_state_n  = r_state;
        w_op_n     = r_op;
        w_result_n = r_result;
        w_tmo_n    = r_tmo;
        w_a_shift  = 1'b0;
        w_a_clear  = 1'b0;
        w_a_load   = 1'b0;
        w_b_shift  = 1'b0;
        w_b_clear  = 1'b0;

        if (w_clr) begin
            // Clear outranks everything, including a same-cycle alu_done.
            w_a_clear  = 1'b1;
            w_b_clear  = 1'b1;
            w_op_n     = OP_ADD;
            w_result_n = '0;
            w_tmo_n    = '0;
            w_state_n  = ENTER_A;
        end else begin
            case (r_state)
                ENTER_A: begin
                    if (w_dig) begin
                        w_a_shift = 1'b1;
                    end else if (w_opk) begin
                        w_op_n    = key_to_op(key_code);
                        w_b_clear = 1'b1;
                        w_state_n = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (w_dig) begin
                        w_b_shift = 1'b1;
                    end else if (w_opk && (w_b_count == '0)) begin
                        w_op_n = key_to_op(key_code);
                    end else if (w_eq && (w_b_count != '0)) begin
                        w_state_n = EXEC;
                    end
                end
                EXEC, WAIT: begin
                    if (r_state == EXEC) begin
                        w_state_n = WAIT;
                        w_tmo_n   = '0;
                    end
                    if (alu_done) begin
                        if (alu_ovf) begin
                            w_state_n = ERR;
                        end else begin
                            w_result_n = alu_result;
                            w_state_n  = SHOW;
                        end
                    end else if ((r_state == WAIT) && enable) begin
                        if (r_tmo == TW'(TIMEOUT - 1)) begin
                            w_state_n = ERR;
                        end else begin
                            w_tmo_n = r_tmo + 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (w_dig) begin
                        w_a_clear = 1'b1;
                        w_a_shift = 1'b1;
                        w_state_n = ENTER_A;
                    end
`ifdef CALC_SEQ_CHAIN_EN
                    else if (w_opk) begin
                        w_a_load  = 1'b1;
                        w_op_n    = key_to_op(key_code);
                        w_b_clear = 1'b1;
                        w_state_n = ENTER_B;
                    end
`endif
                end
                default: ;
            endcase
        end

        // Display is registered from next-state values so it tracks the key
        // with one cycle of latency; EXEC/WAIT keep whatever was shown.
        case (w_state_n)
            ENTER_A: w_display_n = w_a_next;
            ENTER_B: w_display_n = w_b_next;
            SHOW:    w_display_n = w_result_n;
            ERR:     w_display_n = {DIGITS{4'hE}};
            default: w_display_n = r_display;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ENTER_A;
            r_op      <= OP_ADD;
            r_result  <= '0;
            r_tmo     <= '0;
            r_display <= '0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_op      <= w_op_n;
            r_result  <= w_result_n;
            r_tmo     <= w_tmo_n;
            r_display <= w_display_n;
            r_start   <= (w_state_n == EXEC);
            r_busy    <= (w_state_n == EXEC) || (w_state_n == WAIT);
            r_error   <= (w_state_n == ERR);
        end
    end

    assign alu_op        = r_op;
    assign alu_start     = r_start;
    assign busy          = r_busy;
    assign error         = r_error;
    assign display_value = r_display;

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic        alu_ovf;
    logic [15:0] alu_result;
    logic [15:0] display_value;
    logic        busy;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } start_t;

    typedef struct packed {
        logic [15:0] disp;
        logic        err;
    } comp_t;

    start_t start_q[$];
    comp_t  comp_q[$];
    logic   prev_busy = 1'b0;

    always #5 clk = ~clk;

    calc_sequencer #(.DIGITS(4), .TIMEOUT(255)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_start     (alu_start),
        .alu_done      (alu_done),
        .alu_ovf       (alu_ovf),
        .alu_result    (alu_result),
        .display_value (display_value),
        .busy          (busy),
        .error         (error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every start pulse and every exit from EXEC/WAIT is matched
    // against the next queued expectation.
    always @(negedge clk) begin
        start_t s;
        comp_t  c;
        if (alu_start) begin
            if (start_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL start_unexpected: got pulse expected none");
            end else begin
                s = start_q.pop_front();
                chk("start_alu_a", {16'h0, alu_a}, {16'h0, s.a});
                chk("start_alu_b", {16'h0, alu_b}, {16'h0, s.b});
                chk("start_alu_op", {30'h0, alu_op}, {30'h0, s.op});
            end
        end
        if (prev_busy && !busy) begin
            if (comp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL busy_exit_unexpected: got exit expected none");
            end else begin
                c = comp_q.pop_front();
                chk("exit_display", {16'h0, display_value}, {16'h0, c.disp});
                chk("exit_error", {31'h0, error}, {31'h0, c.err});
            end
        end
        prev_busy = busy;
    end

    task automatic key(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic keys(input logic [3:0] seq[$]);
        foreach (seq[i]) key(seq[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start();
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (alu_start) seen = 1'b1;
            else @(negedge clk);
        end
        chk("start_seen", {31'h0, seen}, 32'h1);
    endtask

    task automatic done_pulse(input int d, input logic [15:0] res, input logic ovf);
        repeat (d) @(negedge clk);
        alu_done   = 1'b1;
        alu_result = res;
        alu_ovf    = ovf;
        @(negedge clk);
        alu_done = 1'b0;
        alu_ovf  = 1'b0;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_alu_a"}, {16'h0, alu_a}, 32'h0);
        chk({tag, "_alu_b"}, {16'h0, alu_b}, 32'h0);
        chk({tag, "_alu_op"}, {30'h0, alu_op}, 32'h0);
        chk({tag, "_disp"}, {16'h0, display_value}, 32'h0);
        chk({tag, "_start"}, {31'h0, alu_start}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_error"}, {31'h0, error}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset      = 1'b0;
        enable     = 1'b1;
        key_valid  = 1'b0;
        key_code   = 4'h0;
        alu_done   = 1'b0;
        alu_ovf    = 1'b0;
        alu_result = 16'h0;
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // 12 + 3 = -> 15
        start_q.push_back('{16'h0012, 16'h0003, 2'b00});
        comp_q.push_back('{16'h0015, 1'b0});
        keys('{4'h1, 4'h2});
        chk("entry_a_disp", {16'h0, display_value}, 32'h0012);
        keys('{4'hA, 4'h3});
        chk("entry_b_disp", {16'h0, display_value}, 32'h0003);
        key(4'hE);
        wait_start();
        done_pulse(3, 16'h0015, 1'b0);
        idle(2);
        chk("add_disp", {16'h0, display_value}, 32'h0015);
        chk("add_busy", {31'h0, busy}, 32'h0);

        // 5 - 2 =, then '=' again must not restart
        key(4'hF);
        start_q.push_back('{16'h0005, 16'h0002, 2'b01});
        comp_q.push_back('{16'h0003, 1'b0});
        keys('{4'h5, 4'hB, 4'h2, 4'hE});
        wait_start();
        done_pulse(1, 16'h0003, 1'b0);
        key(4'hE);
        idle(5);
        chk("sub_repeat_disp", {16'h0, display_value}, 32'h0003);

        // Saturation, ignored '=', operator replacement only while B empty
        key(4'hF);
        keys('{4'h1, 4'h2, 4'h3, 4'h4, 4'h5});
        chk("sat_alu_a", {16'h0, alu_a}, 32'h1234);
        chk("sat_disp", {16'h0, display_value}, 32'h1234);
        key(4'hE);
        idle(2);
        chk("eq_in_a_busy", {31'h0, busy}, 32'h0);
        chk("eq_in_a_disp", {16'h0, display_value}, 32'h1234);
        key(4'hA);
        chk("enter_b_disp", {16'h0, display_value}, 32'h0);
        key(4'hE);
        idle(2);
        chk("eq_empty_b_busy", {31'h0, busy}, 32'h0);
        keys('{4'hB, 4'hC});
        chk("op_replace", {30'h0, alu_op}, 32'h2);
        keys('{4'h7, 4'hA});
        chk("op_locked", {30'h0, alu_op}, 32'h2);
        start_q.push_back('{16'h1234, 16'h0007, 2'b10});
        comp_q.push_back('{16'h8638, 1'b0});
        key(4'hE);
        wait_start();
        done_pulse(1, 16'h8638, 1'b0);
        idle(2);
        chk("mul_disp", {16'h0, display_value}, 32'h8638);

        // Timeout
        key(4'hF);
        start_q.push_back('{16'h0009, 16'h0009, 2'b10});
        comp_q.push_back('{16'hEEEE, 1'b1});
        keys('{4'h9, 4'hC, 4'h9, 4'hE});
        wait_start();
        idle(250);
        chk("tmo_early_error", {31'h0, error}, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (error) seen = 1'b1;
            else @(negedge clk);
        end
        chk("tmo_error", {31'h0, seen}, 32'h1);
        chk("tmo_disp", {16'h0, display_value}, 32'hEEEE);
        key(4'h5);
        chk("err_digit_ignored", {16'h0, display_value}, 32'hEEEE);
        key(4'hF);
        chk_idle_zero("clr_err");

        // Async reset in WAIT
        start_q.push_back('{16'h0001, 16'h0001, 2'b00});
        comp_q.push_back('{16'h0000, 1'b0});
        keys('{4'h1, 4'hA, 4'h1, 4'hE});
        wait_start();
        idle(3);
        #2 reset = 1'b0;
        #1;
        chk_idle_zero("async_rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Overflow
        start_q.push_back('{16'h0002, 16'h0003, 2'b00});
        comp_q.push_back('{16'hEEEE, 1'b1});
        keys('{4'h2, 4'hA, 4'h3, 4'hE});
        wait_start();
        done_pulse(2, 16'h0005, 1'b1);
        chk("ovf_error", {31'h0, error}, 32'h1);
        key(4'hF);

        // Clear and done in the same cycle, then a stray done
        start_q.push_back('{16'h0004, 16'h0004, 2'b00});
        comp_q.push_back('{16'h0000, 1'b0});
        keys('{4'h4, 4'hA, 4'h4, 4'hE});
        wait_start();
        idle(2);
        key_valid  = 1'b1;
        key_code   = 4'hF;
        alu_done   = 1'b1;
        alu_result = 16'h0008;
        @(negedge clk);
        key_valid = 1'b0;
        alu_done  = 1'b0;
        chk("clr_done_disp", {16'h0, display_value}, 32'h0);
        chk("clr_done_error", {31'h0, error}, 32'h0);
        alu_done   = 1'b1;
        alu_result = 16'h0099;
        @(negedge clk);
        alu_done = 1'b0;
        idle(2);
        chk("stray_done_disp", {16'h0, display_value}, 32'h0);
        chk("stray_done_busy", {31'h0, busy}, 32'h0);

        // enable low blocks keys
        enable = 1'b0;
        key(4'h7);
        chk("en_low_alu_a", {16'h0, alu_a}, 32'h0);
        chk("en_low_disp", {16'h0, display_value}, 32'h0);
        enable = 1'b1;
        key(4'h7);
        chk("en_high_alu_a", {16'h0, alu_a}, 32'h0007);
        key(4'hF);

        // Operator in SHOW
        start_q.push_back('{16'h0012, 16'h0003, 2'b00});
        comp_q.push_back('{16'h0015, 1'b0});
        keys('{4'h1, 4'h2, 4'hA, 4'h3, 4'hE});
        wait_start();
        done_pulse(2, 16'h0015, 1'b0);
`ifdef CALC_SEQ_CHAIN_EN
        start_q.push_back('{16'h0015, 16'h0004, 2'b00});
        comp_q.push_back('{16'h0019, 1'b0});
        keys('{4'hA, 4'h4, 4'hE});
        wait_start();
        done_pulse(2, 16'h0019, 1'b0);
        idle(2);
        chk("chain_disp", {16'h0, display_value}, 32'h0019);
`else
        key(4'hA);
        chk("show_op_disp", {16'h0, display_value}, 32'h0015);
        key(4'h4);
        chk("show_digit_alu_a", {16'h0, alu_a}, 32'h0004);
        chk("show_digit_disp", {16'h0, display_value}, 32'h0004);
        key(4'hE);
        idle(2);
        chk("show_eq_busy", {31'h0, busy}, 32'h0);
`endif

        idle(3);
        chk("start_q_drained", start_q.size(), 32'h0);
        chk("comp_q_drained", comp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
